// File: rtl/mux_nw_reg.sv
// mux_nw_reg: N-channel, W-bit registered multiplexer with valid/ready handshakes.
//
// A single output pipeline register is loaded from one granted input channel per cycle.
// Fixed mode grants channel j. Round-robin mode scans from an internal pointer, wrapping
// modulo N. Round-robin mode exists only when the macro MUX_RR_EN is defined; without it
// `mode` is ignored and the block always uses the fixed select.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_data   - N packed words, channel k at [k*W +: W]
//   i_valid  - per-channel valid
//   i_ready  - per-channel accept (one-hot or zero), combinational
//   j        - channel select for fixed mode
//   mode     - 0 fixed, 1 round-robin (honoured only with MUX_RR_EN)
//   o        - registered output word
//   o_valid  - o holds an unconsumed word
//   o_ready  - consumer accepts o
//   o_chan   - index of the channel that supplied o
module mux_nw_reg #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  i_data,
  input  logic [N-1:0]    i_valid,
  output logic [N-1:0]    i_ready,
  input  logic [SW-1:0]   j,
  input  logic            mode,
  output logic [W-1:0]    o,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [SW-1:0]   o_chan
);

  logic          ld;
  logic          fix_any;
  logic [SW-1:0] fix_idx;
  logic          gnt_any;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;

  assign ld = !o_valid || o_ready;

  // Fixed select: a j beyond N-1 matches no channel and so grants nothing.
  always_comb begin
    fix_any = 1'b0;
    fix_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_valid[k] && (j == SW'(k))) begin
        fix_any = 1'b1;
        fix_idx = SW'(k);
      end
    end
  end

`ifdef MUX_RR_EN
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_d;
  logic          rr_any;
  logic [SW-1:0] rr_idx;

  // Pick the valid channel with the smallest forward distance from ptr (modulo N).
  always_comb begin
    int unsigned best;
    int unsigned dist;
    rr_any = 1'b0;
    rr_idx = '0;
    best   = N;
    for (int unsigned k = 0; k < N; k++) begin
      dist = (k >= 32'(ptr_q)) ? (k - 32'(ptr_q)) : (k + N - 32'(ptr_q));
      if (i_valid[k] && (dist < best)) begin
        best   = dist;
        rr_any = 1'b1;
        rr_idx = SW'(k);
      end
    end
  end

  assign gnt_any = mode ? rr_any : fix_any;
  assign gnt_idx = mode ? rr_idx : fix_idx;

  always_comb begin
    ptr_d = ptr_q;
    if (mode && gnt_any && ld) begin
      ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign gnt_any     = fix_any;
  assign gnt_idx     = fix_idx;
`endif

  always_comb begin
    gnt_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt_idx == SW'(k)) begin
        gnt_data = i_data[k*W +: W];
      end
    end
  end

  // Gated by rst_n so no channel sees an accept while the register is held in reset.
  always_comb begin
    i_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      i_ready[k] = rst_n && ld && gnt_any && (gnt_idx == SW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o       <= '0;
      o_valid <= 1'b0;
      o_chan  <= '0;
    end else if (ld) begin
      if (gnt_any) begin
        o       <= gnt_data;
        o_chan  <= gnt_idx;
        o_valid <= 1'b1;
      end else begin
        // Drain: o and o_chan keep the last word.
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nw_reg.sv
// Testbench for mux_nw_reg: constant vector table, hand sequences for reset and the N=3
// wrap case, and randomized traffic checked against a behavioural model.
module tb_mux_nw_reg;

  localparam logic [31:0] DATA = 32'hDDCCBBAA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_data;
  logic [3:0]  i_valid;
  logic [3:0]  i_ready;
  logic [1:0]  j;
  logic        mode;
  logic [7:0]  o;
  logic        o_valid;
  logic        o_ready;
  logic [1:0]  o_chan;

  logic [23:0] d3;
  logic [2:0]  v3;
  logic [2:0]  r3;
  logic [1:0]  j3;
  logic        m3;
  logic [7:0]  o3;
  logic        ov3;
  logic        or3;
  logic [1:0]  oc3;

  int n_vec = 0;
  int n_bad = 0;

  // Model state
  logic [7:0] m_o;
  logic       m_ov;
  logic [1:0] m_oc;
  int         m_ptr;

  always #5 clk = ~clk;

  mux_nw_reg #(.N(4), .W(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .j       (j),
    .mode    (mode),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_chan  (o_chan)
  );

  mux_nw_reg #(.N(3), .W(8)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (d3),
    .i_valid (v3),
    .i_ready (r3),
    .j       (j3),
    .mode    (m3),
    .o       (o3),
    .o_valid (ov3),
    .o_ready (or3),
    .o_chan  (oc3)
  );

  typedef struct {
    string      name;
    bit         rst;
    logic [3:0] v;
    logic [1:0] jj;
    logic       md;
    logic       ordy;
    logic [3:0] e_rdy;
    logic [7:0] e_o;
    logic       e_ov;
    logic [1:0] e_oc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit rr_on(input logic md);
`ifdef MUX_RR_EN
    return md;
`else
    return 1'b0 & md;
`endif
  endfunction

  function automatic int ref_grant(input logic [3:0] v, input logic [1:0] jj, input bit rr);
    if (rr) begin
      for (int s = 0; s < 4; s++) begin
        int c;
        c = (m_ptr + s) % 4;
        if (((v >> c) & 4'd1) != 4'd0) return c;
      end
      return -1;
    end
    if (((v >> jj) & 4'd1) != 4'd0) return int'(jj);
    return -1;
  endfunction

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic run_vec(input string nm, input logic [31:0] d, input logic [3:0] v,
                         input logic [1:0] jj, input logic md, input logic ordy,
                         input logic [3:0] e_rdy, input logic [7:0] e_o, input logic e_ov,
                         input logic [1:0] e_oc);
    i_data = d; i_valid = v; j = jj; mode = md; o_ready = ordy;
    #1;
    chk({nm, " i_ready"}, 32'(i_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({nm, " o"}, 32'(o), 32'(e_o));
    chk({nm, " o_valid"}, 32'(o_valid), 32'(e_ov));
    chk({nm, " o_chan"}, 32'(o_chan), 32'(e_oc));
  endtask

  task automatic model_vec(input string nm, input logic [31:0] d, input logic [3:0] v,
                           input logic [1:0] jj, input logic md, input logic ordy);
    int g;
    bit can_load;
    logic [3:0] er;
    g = ref_grant(v, jj, rr_on(md));
    can_load = !m_ov || ordy;
    er = (can_load && g >= 0) ? 4'(1 << g) : 4'b0;
    if (can_load) begin
      if (g >= 0) begin
        m_o  = 8'(d >> (8 * g));
        m_ov = 1'b1;
        m_oc = 2'(g);
        if (rr_on(md)) m_ptr = (g + 1) % 4;
      end else begin
        m_ov = 1'b0;
      end
    end
    run_vec(nm, d, v, jj, md, ordy, er, m_o, m_ov, m_oc);
  endtask

  // Asserts reset between edges with traffic offered, checks the immediate effect.
  task automatic do_reset(input string nm);
    i_valid = 4'hF; o_ready = 1'b1; v3 = 3'b111; or3 = 1'b1;
    #4;
    rst_n = 1'b0;
    #1;
    chk({nm, " rst o"}, 32'(o), 32'h0);
    chk({nm, " rst o_valid"}, 32'(o_valid), 32'h0);
    chk({nm, " rst o_chan"}, 32'(o_chan), 32'h0);
    chk({nm, " rst i_ready"}, 32'(i_ready), 32'h0);
    chk({nm, " rst i_ready n3"}, 32'(r3), 32'h0);
    m_o = '0; m_ov = 1'b0; m_oc = '0; m_ptr = 0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input string nm, input bit r, input logic [3:0] v, input logic [1:0] jj,
                     input logic md, input logic ordy, input logic [3:0] e_rdy,
                     input logic [7:0] e_o, input logic e_ov, input logic [1:0] e_oc);
    vec_t t;
    t.name = nm; t.rst = r; t.v = v; t.jj = jj; t.md = md; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_o = e_o; t.e_ov = e_ov; t.e_oc = e_oc;
    tbl.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0;
    i_data = DATA; i_valid = '0; j = '0; mode = 1'b0; o_ready = 1'b0;
    d3 = 24'hCCBBAA; v3 = '0; j3 = '0; m3 = 1'b0; or3 = 1'b0;
    m_o = '0; m_ov = 1'b0; m_oc = '0; m_ptr = 0;

    // Fixed sweep
    add("sweep0", 0, 4'hF, 2'd0, 0, 1, 4'b0001, 8'hAA, 1, 2'd0);
    add("sweep1", 0, 4'hF, 2'd1, 0, 1, 4'b0010, 8'hBB, 1, 2'd1);
    add("sweep2", 0, 4'hF, 2'd2, 0, 1, 4'b0100, 8'hCC, 1, 2'd2);
    add("sweep3", 0, 4'hF, 2'd3, 0, 1, 4'b1000, 8'hDD, 1, 2'd3);
    // Backpressure
    add("bp_load", 0, 4'hF, 2'd0, 0, 1, 4'b0001, 8'hAA, 1, 2'd0);
    add("bp_st1",  0, 4'hF, 2'd1, 0, 0, 4'b0000, 8'hAA, 1, 2'd0);
    add("bp_st2",  0, 4'hF, 2'd1, 0, 0, 4'b0000, 8'hAA, 1, 2'd0);
    add("bp_st3",  0, 4'hF, 2'd1, 0, 0, 4'b0000, 8'hAA, 1, 2'd0);
    add("bp_rel",  0, 4'hF, 2'd2, 0, 1, 4'b0100, 8'hCC, 1, 2'd2);
    // Invalid select, then drain
    add("inv_hold",  0, 4'b1101, 2'd1, 0, 0, 4'b0000, 8'hCC, 1, 2'd2);
    add("inv_drain", 0, 4'b1101, 2'd1, 0, 1, 4'b0000, 8'hCC, 0, 2'd2);
    add("inv_idle",  0, 4'b1101, 2'd1, 0, 1, 4'b0000, 8'hCC, 0, 2'd2);
`ifdef MUX_RR_EN
    add("rr0", 1, 4'b1011, 2'd0, 1, 1, 4'b0001, 8'hAA, 1, 2'd0);
    add("rr1", 0, 4'b1011, 2'd0, 1, 1, 4'b0010, 8'hBB, 1, 2'd1);
    add("rr2", 0, 4'b1011, 2'd0, 1, 1, 4'b1000, 8'hDD, 1, 2'd3);
    add("rr3", 0, 4'b1011, 2'd0, 1, 1, 4'b0001, 8'hAA, 1, 2'd0);
    add("rr4", 0, 4'b1011, 2'd0, 1, 1, 4'b0010, 8'hBB, 1, 2'd1);
    add("rr5", 0, 4'b1011, 2'd0, 1, 1, 4'b1000, 8'hDD, 1, 2'd3);
`else
    add("norr0", 1, 4'hF, 2'd2, 1, 1, 4'b0100, 8'hCC, 1, 2'd2);
    add("norr1", 0, 4'hF, 2'd2, 1, 1, 4'b0100, 8'hCC, 1, 2'd2);
    add("norr2", 0, 4'hF, 2'd2, 1, 1, 4'b0100, 8'hCC, 1, 2'd2);
`endif

    #3;
    chk("init o", 32'(o), 32'h0);
    chk("init o_valid", 32'(o_valid), 32'h0);
    chk("init i_ready", 32'(i_ready), 32'h0);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset(tbl[k].name);
      run_vec(tbl[k].name, DATA, tbl[k].v, tbl[k].jj, tbl[k].md, tbl[k].ordy,
              tbl[k].e_rdy, tbl[k].e_o, tbl[k].e_ov, tbl[k].e_oc);
    end

    // Async reset mid-stream: hold 0xBB (ptr advanced past 0 in round-robin builds).
    do_reset("mid_pre");
    model_vec("mid_load", DATA, 4'b0010, 2'd1, 1, 1);
    chk("mid_load o", 32'(o), 32'hBB);
    do_reset("mid");
    model_vec("mid_restart", DATA, 4'hF, 2'd0, 1, 1);
    chk("mid_restart chan", 32'(o_chan), 32'h0);

    // N=3 build: out-of-range select, then wrap.
    do_reset("n3");
    i_valid = '0;
    d3 = 24'hCCBBAA; v3 = 3'b111; j3 = 2'd3; m3 = 1'b0; or3 = 1'b1;
    #1;
    chk("n3 j3 i_ready", 32'(r3), 32'h0);
    @(posedge clk); #1;
    chk("n3 j3 o_valid", 32'(ov3), 32'h0);
`ifdef MUX_RR_EN
    m3 = 1'b1; v3 = 3'b100;
    #1;
    chk("n3 rr2 i_ready", 32'(r3), 32'b100);
    @(posedge clk); #1;
    chk("n3 rr2 o_chan", 32'(oc3), 32'h2);
    chk("n3 rr2 o", 32'(o3), 32'hCC);
    v3 = 3'b001;
    #1;
    chk("n3 wrap i_ready", 32'(r3), 32'b001);
    @(posedge clk); #1;
    chk("n3 wrap o_chan", 32'(oc3), 32'h0);
    chk("n3 wrap o", 32'(o3), 32'hAA);
`else
    m3 = 1'b1; j3 = 2'd1;
    #1;
    chk("n3 fix i_ready", 32'(r3), 32'b010);
    @(posedge clk); #1;
    chk("n3 fix o_chan", 32'(oc3), 32'h1);
    chk("n3 fix o", 32'(o3), 32'hBB);
`endif
    v3 = '0;

    // Randomized traffic against the model.
    do_reset("rand");
    for (int n = 0; n < 400; n++) begin
      model_vec("rand", $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_nw_reg.md
# mux_nw_reg

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input channel and on the output. It generalises the lab 2:1 combinational mux (ports i0/i1, select j, output o) to N data channels of arbitrary width. The output is a single pipeline register, and an optional round-robin scan mode is available. It sits between several data producers and one consumer in lab datapaths.

## Interface
- N, default 4: number of input channels, ≥2.
- W, default 8: data width per channel, ≥1.
- SW, default $clog2(N): select/channel-index width. Derived; do not override.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_data  in  N*W  channel k occupies [k*W +: W].
- i_valid  in  N  bit k: channel k offers a word.
- i_ready  out  N  one-hot or zero; bit k high means channel k's word is accepted this edge.
- j  in  SW  channel select in fixed mode.
- mode  in  1  0 = fixed select, 1 = round-robin. Ignored unless MUX_RR_EN is defined.
- o  out  W  registered output word.
- o_valid  out  1  o holds an unconsumed word.
- o_ready  in  1  consumer accepts o this edge.
- o_chan  out  SW  index of the channel that supplied o.

## Operation
- **Load enable:** ld = !o_valid || o_ready.
- **Fixed mode (mode=0):**
  - grant = channel j if i_valid[j] and j < N.
  - j ≥ N (possible when N is not a power of 2) gives no grant.
- **Round-robin mode (mode=1):**
  - Internal pointer ptr (SW bits).
  - Scan ptr, ptr+1, …, wrapping modulo N (not modulo 2^SW). The first channel with i_valid set is granted.
  - On each accepted grant to channel k, ptr ← (k+1) mod N. With no grant, ptr holds.
- **Handshake:**
  - i_ready[k] = ld && grant==k. This path is combinational.
  - On an edge with i_ready[k]: o ← word k, o_chan ← k, o_valid ← 1.
  - On an edge with ld, o_valid && o_ready, and no grant: o_valid ← 0. o and o_chan keep their values.
- **Mode switch:** takes effect on the next selection. ptr is never cleared by a mode change.
- **Reset:** while rst_n is low, all of o=0, o_valid=0, o_chan=0, ptr=0 take effect immediately, independent of clk. A held word is discarded. No i_ready is asserted during reset.

## Timing
- Latency: exactly 1 cycle from the accept edge to o_valid/o.
- Throughput: one word per cycle while o_ready=1 and some selected channel is valid.
- Stall: while o_valid && !o_ready, o, o_chan and o_valid are held stable and all i_ready are 0.
- Simultaneous consume and load on one edge: the new word replaces the old one, and o_valid stays 1 with no bubble.
- No combinational path from o_ready to o. There is a combinational path from o_ready, i_valid, j and mode to i_ready.
- First load is possible on the first rising edge after rst_n deasserts.

## Configuration
- MUX_RR_EN
  - **Defined:** round-robin mode and ptr are present, and mode is honoured.
  - **Undefined:** ptr logic is not compiled, mode is ignored, and the block always behaves as fixed mode.

## Test plan
Default parameters N=4, W=8; i_data = {0xDD,0xCC,0xBB,0xAA}.
- **Fixed sweep:** mode=0, i_valid=4'b1111, o_ready=1, j stepping 0,1,2,3 on successive cycles → o = 0xAA,0xBB,0xCC,0xDD and o_chan = 0,1,2,3, each one cycle after its select.
- **Backpressure:** load 0xAA, then o_ready=0 for 3 cycles → o=0xAA, o_valid=1, i_ready=0 throughout. Raise o_ready with j=2 → 0xCC appears on the next edge with o_valid never dropping.
- **Invalid select:** j=1, i_valid=4'b1101 → no i_ready. After the held word drains, o_valid=0 and o is unchanged.
- **Round-robin fairness:** mode=1, i_valid=4'b1011, o_ready=1 → o_chan sequence 0,1,3,0,1,3; i_ready one-hot each cycle.
- **Round-robin wrap, N=3 build:** grant channel 2 → ptr=0 (not 3). With i_valid=3'b001 the next grant is channel 0.
- **Async reset mid-stream:** assert rst_n=0 between edges while o=0xBB, o_valid=1 → o=0x00, o_valid=0, o_chan=0 immediately. After release, round-robin restarts at channel 0.
- **Macro undefined:** mode=1, j=2, i_valid=4'b1111 → every grant goes to channel 2 (o=0xCC).
